// File: rtl/tx_fsrc_ctrl.sv
// TX FSRC sequencing controller: computes per-lane accumulator seeds,
// waits for trigger, loads seeds, delays, then pulses start/stop.
module tx_fsrc_ctrl #(
    parameter int NUM_SAMPLES = 16,
    parameter int ACCUM_WIDTH = 64,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_enable,
    input  logic                             cfg_trig_mode,
    input  logic [ACCUM_WIDTH-1:0]           cfg_accum_init,
    input  logic [ACCUM_WIDTH-1:0]           cfg_accum_add,
    input  logic [DELAY_WIDTH-1:0]           cfg_start_delay,
    input  logic                             arm,
    input  logic                             stop_req,
    input  logic                             ext_trig,
    output logic                             enable,
    output logic                             start,
    output logic                             stop,
    output logic                             accum_set,
    output logic [NUM_SAMPLES*ACCUM_WIDTH-1:0] accum_set_val,
    output logic [ACCUM_WIDTH-1:0]           accum_add_val,
    output logic                             busy,
    output logic                             running,
    output logic [15:0]                      run_count
);

    localparam int IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE, CALC, WAIT_TRIG, SET, DELAY, RUN, STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic [ACCUM_WIDTH-1:0] init_q, add_q, seed_q, seed_d;
    logic [ACCUM_WIDTH-1:0] slot_q [NUM_SAMPLES];
    logic [DELAY_WIDTH-1:0] dly_q, cnt_q;
    logic                   trig_prev_q, trig_edge;
    logic                   enable_q, start_q, stop_q, set_q;
    logic [15:0]            run_cnt_q;

    assign trig_edge = ext_trig & ~trig_prev_q;
    assign seed_d    = (idx_q == '0) ? init_q : seed_q + add_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (arm) state_d = CALC;
            CALC:      if (idx_q == LAST) state_d = WAIT_TRIG;
            WAIT_TRIG: if (!cfg_trig_mode || trig_edge) state_d = SET;
            SET:       state_d = (dly_q == '0) ? RUN : DELAY;
            DELAY:     if (cnt_q == DELAY_WIDTH'(1)) state_d = RUN;
            RUN:       state_d = RUN;
            STOP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (stop_req && state_q != IDLE && state_q != STOP) state_d = STOP;
        // Enable drop wins over everything and never produces a stop pulse
        if (!cfg_enable) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            init_q      <= '0;
            add_q       <= '0;
            seed_q      <= '0;
            dly_q       <= '0;
            cnt_q       <= '0;
            trig_prev_q <= 1'b0;
            enable_q    <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            set_q       <= 1'b0;
            run_cnt_q   <= '0;
            for (int k = 0; k < NUM_SAMPLES; k++) slot_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= ext_trig;
            enable_q    <= cfg_enable;
            set_q       <= (state_d == SET);
            start_q     <= (state_d == RUN) && (state_q != RUN);
            stop_q      <= (state_d == STOP);
            if (state_q == RUN && state_d == STOP)
                run_cnt_q <= run_cnt_q + 16'd1;
            if (state_q == IDLE && state_d == CALC) begin
                init_q <= cfg_accum_init;
                add_q  <= cfg_accum_add;
                dly_q  <= cfg_start_delay;
                idx_q  <= '0;
            end
            if (state_q == CALC) begin
                slot_q[idx_q] <= seed_d;
                seed_q        <= seed_d;
                idx_q         <= idx_q + IW'(1);
            end
            if (state_q == SET)
                cnt_q <= dly_q;
            else if (state_q == DELAY)
                cnt_q <= cnt_q - DELAY_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_pack
        assign accum_set_val[k*ACCUM_WIDTH +: ACCUM_WIDTH] = slot_q[k];
    end

    assign enable        = enable_q;
    assign start         = start_q;
    assign stop          = stop_q;
    assign accum_set     = set_q;
    assign accum_add_val = add_q;
    assign busy          = (state_q != IDLE);
    assign running       = (state_q == RUN);
    assign run_count     = run_cnt_q;

endmodule

// File: doc/tx_fsrc_ctrl.md
Name: tx_fsrc_ctrl

Overview:
Sequencing controller for the TX FSRC hole-insertion datapath. On an arm request it computes the per-sample accumulator seed values (init + k*add) iteratively. It then waits for an optional external trigger, loads the seeds with a one-cycle accum_set, and counts a programmable delay. It then issues the one-cycle start pulse, and on a stop request issues the one-cycle stop pulse. Sits between the AXI register map and the FSRC TX core; drives its enable/start/stop/accum_set/accum_set_val/accum_add_val inputs.

Parameters:
NUM_SAMPLES, 16, number of accumulator lanes (seed slots)
ACCUM_WIDTH, 64, accumulator width; all seed arithmetic is modulo 2^ACCUM_WIDTH
DELAY_WIDTH, 16, width of start-delay counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_enable  in  1  FSRC enable from register map
cfg_trig_mode  in  1  0 = internal (no wait), 1 = wait for ext_trig rising edge
cfg_accum_init  in  ACCUM_WIDTH  seed of slot 0
cfg_accum_add  in  ACCUM_WIDTH  per-cycle phase increment; also the per-slot seed step
cfg_start_delay  in  DELAY_WIDTH  cycles between accum_set and start
arm  in  1  single-cycle request to begin a sequence
stop_req  in  1  single-cycle request to end or abort a sequence
ext_trig  in  1  external sync, level, synchronous to clk
enable  out  1  to FSRC core
start  out  1  one-cycle pulse to FSRC core
stop  out  1  one-cycle pulse to FSRC core
accum_set  out  1  one-cycle seed-load pulse
accum_set_val  out  NUM_SAMPLES*ACCUM_WIDTH  packed seeds; slot k at [k*ACCUM_WIDTH +: ACCUM_WIDTH]
accum_add_val  out  ACCUM_WIDTH  registered copy of cfg_accum_add, captured on arm
busy  out  1  state != IDLE
running  out  1  state == RUN
run_count  out  16  completed runs (RUN→STOP transitions), wraps at 0xFFFF→0

Behaviour:
- Reset values: state=IDLE; all outputs 0; all seed slots 0; counters 0; ext_trig edge register 0.
- enable = cfg_enable, registered (1-cycle latency).
- Priority, highest first: reset > cfg_enable low > stop_req > normal transition.
- cfg_enable low in any state: next state IDLE, no stop pulse, seeds retained. The core self-clears on enable drop.
- stop_req in any non-IDLE state other than STOP → STOP. stop_req in IDLE is ignored.
- IDLE: arm with cfg_enable high → CALC. On this transition capture cfg_accum_init, cfg_accum_add and cfg_start_delay, clear idx. arm is ignored in every other state.
- CALC: lasts exactly NUM_SAMPLES cycles, one slot per cycle.
  - idx=0: slot0 = init.
  - idx=k: slot k = slot k-1 + add (truncate carry).
  - After idx=NUM_SAMPLES-1 → WAIT_TRIG.
- WAIT_TRIG: lasts 1 cycle if trig_mode=0, then → SET.
  - If trig_mode=1, stay until a rising edge of ext_trig is detected (ext_trig=1 and registered previous value=0) while in this state.
  - Edges before entry are discarded. ext_trig held high on entry is not an edge.
- SET: accum_set=1 for exactly this one cycle; accum_set_val is stable from CALC exit onward.
  - cfg_start_delay==0 → RUN; else load counter=cfg_start_delay → DELAY.
- DELAY: decrement each cycle; leave after exactly cfg_start_delay cycles → RUN.
- RUN: start=1 on the first RUN cycle only. Remains in RUN until stop_req or cfg_enable low.
- STOP: stop=1 for exactly one cycle; run_count increments only if the previous state was RUN; → IDLE.
  - An abort from CALC/WAIT_TRIG/SET/DELAY still pulses stop but does not increment run_count.
- start and stop are never high in the same cycle.
- stop_req in the same cycle as RUN entry: start still pulses (state is RUN); STOP follows next cycle.
- Timing, trig_mode=0, arm sampled at edge of cycle 0, N=NUM_SAMPLES, D=delay:
  - CALC cycles 1..N
  - WAIT_TRIG cycle N+1
  - SET cycle N+2
  - start at cycle N+3+D

Test Plan:
- N=4, W=64, init=0x10, add=0x4000_0000_0000_0000, delay=3, trig_mode=0, arm at cycle 0 → slots 0x10, 0x4000…0010, 0x8000…0010, 0xC000…0010; accum_set high only cycle 6; start high only cycle 10.
- Wrap: init=0xFFFF_FFFF_FFFF_FFFF, add=1 → slots 0xFFFF_FFFF_FFFF_FFFF, 0, 1, 2.
- trig_mode=1, ext_trig held high before arm, then low 5 cycles, then high → accum_set exactly 1 cycle after the new rising edge; no accum_set before it.
- RUN then stop_req → stop one cycle later, run_count 0→1; stop_req in DELAY → stop pulse, no start, run_count unchanged.
- cfg_enable dropped in CALC → enable low next cycle, state IDLE, no stop pulse. A second arm while busy is ignored (no re-CALC).
- Reset asserted in RUN → all outputs 0 next cycle, run_count=0, busy=0.
